framebuffer_pixel_writer: RTL and testbench

- Consumer end of the pixel-coordinate stream produced by the shape/graph generators (bar graphs, coin sprites).
- Accepts (x, y, colour) pixels over a valid/ready handshake and buffers them in a small FIFO.
- Converts each pixel to a linear framebuffer address and issues single-word writes to the VGA framebuffer memory, honouring a memory stall.
- Also provides a full-screen clear sweep on request.

---
 rtl/framebuffer_pixel_writer.sv | 194 +++++++++++++++++++
 tb/tb_framebuffer_pixel_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_pixel_writer.sv
// framebuffer_pixel_writer: buffers (x, y, colour) pixels from the shape generators,
// converts them to linear framebuffer addresses and issues single-word writes that
// respect the memory stall. A clear request sweeps the whole screen with one colour.
// Optional build macro: FB_WRITER_DROP_COUNT_EN adds drop_count/drop_flag outputs that
// report discarded out-of-range pixels.
module framebuffer_pixel_writer #(
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240,
  parameter int unsigned COLOUR_W   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8:0]          in_x,
  input  logic [7:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic                clear_done,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_we,
  input  logic                fb_stall
`ifdef FB_WRITER_DROP_COUNT_EN
  ,
  output logic [15:0]         drop_count,
  output logic                drop_flag
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = 9 + 8 + COLOUR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {StIdle, StClearWait, StClear} state_e;

  state_e                state_q, state_d;
  logic [EntW-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PtrW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]   fb_data_q, fb_data_d;
  logic                  fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [COLOUR_W-1:0]   clr_colour_q, clr_colour_d;
  logic                  clear_done_q, clear_done_d;

  logic                  fifo_empty, fifo_full, push, pop, out_free;
  logic [8:0]            head_x;
  logic [7:0]            head_y;
  logic [COLOUR_W-1:0]   head_colour;
  logic                  head_in_range;
  logic [ADDR_W-1:0]     pix_addr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // New pixels are refused while a clear is pending or running.
  assign in_ready = !reset && !fifo_full && (state_q == StIdle);
  assign push     = in_valid && in_ready;
  assign out_free = !fb_we_q || !fb_stall;

  assign {head_colour, head_y, head_x} = fifo_mem_q[rd_ptr_q[PtrW-1:0]];
  assign head_in_range = (32'(head_x) < H_RES) && (32'(head_y) < V_RES);
  assign pix_addr      = ADDR_W'(32'(head_y) * H_RES + 32'(head_x));

  // Pixel storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PtrW-1:0]] <= {in_colour, in_y, in_x};
  end

  // Next-state logic: FIFO drain, clear hand-off and the clear sweep.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q + {{PtrW{1'b0}}, push};
    rd_ptr_d     = rd_ptr_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    fb_we_d      = fb_we_q;
    clr_cnt_d    = clr_cnt_q;
    clr_colour_d = clr_colour_q;
    clear_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      StIdle, StClearWait: begin
        if (out_free) begin
          fb_we_d = 1'b0;
          if (!fifo_empty) begin
            pop = 1'b1;
            // Out-of-range pixels occupy a slot but produce no write.
            if (head_in_range) begin
              fb_addr_d = pix_addr;
              fb_data_d = head_colour;
              fb_we_d   = 1'b1;
            end
          end else if (state_q == StClearWait) begin
            state_d   = StClear;
            clr_cnt_d = '0;
          end
        end
        if ((state_q == StIdle) && clear_req) begin
          state_d      = StClearWait;
          clr_colour_d = clear_colour;
        end
      end
      StClear: begin
        if (out_free) begin
          if (fb_we_q && (fb_addr_q == LastAddr)) begin
            // Final address accepted by memory this edge.
            fb_we_d      = 1'b0;
            state_d      = StIdle;
            clear_done_d = 1'b1;
          end else begin
            fb_addr_d = clr_cnt_q;
            fb_data_d = clr_colour_q;
            fb_we_d   = 1'b1;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
  end

  // State registers with asynchronous reset abandoning all pending work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_we_q      <= 1'b0;
      clr_cnt_q    <= '0;
      clr_colour_q <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_we_q      <= fb_we_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_colour_q <= clr_colour_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign clear_done = clear_done_q;
  assign clear_busy = (state_q != StIdle);

`ifdef FB_WRITER_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_count_q, drop_count_d;
  logic        drop_flag_q, drop_flag_d;

  assign drop = pop && !head_in_range;

  // Saturating drop counter and sticky flag.
  always_comb begin
    drop_count_d = drop_count_q;
    drop_flag_d  = drop_flag_q;
    if (drop) begin
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
      drop_flag_d = 1'b1;
    end
  end

  // Drop statistics registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
      drop_flag_q  <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      drop_flag_q  <= drop_flag_d;
    end
  end

  assign drop_count = drop_count_q;
  assign drop_flag  = drop_flag_q;
`endif

endmodule

// File: tb/tb_framebuffer_pixel_writer.sv
// Self-checking bench for framebuffer_pixel_writer (320x240, 3-bit colour).
// A reference model holds the ordered list of writes memory must receive; one
// compare process checks every cycle, directed checks pin literal values.
module tb_framebuffer_pixel_writer;

  localparam int HRes = 320;
  localparam int VRes = 240;
  localparam int Total = HRes * VRes;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic [2:0]  in_colour = '0;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_busy, clear_done;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_stall = 1'b0;
`ifdef FB_WRITER_DROP_COUNT_EN
  logic [15:0] drop_count;
  logic        drop_flag;
`endif

  framebuffer_pixel_writer #(
    .H_RES(320), .V_RES(240), .COLOUR_W(3), .FIFO_DEPTH(4), .ADDR_W(17)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_stall(fb_stall)
`ifdef FB_WRITER_DROP_COUNT_EN
    , .drop_count(drop_count), .drop_flag(drop_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [8:0] x; logic [7:0] y; logic [2:0] c;} pix_t;
  typedef struct packed {logic [16:0] addr; logic [2:0] data; logic last; logic is_clr;} exp_t;

  pix_t src_q[$];
  exp_t exp_q[$];
  int   n_checks = 0, n_fail = 0;
  int   acc_cnt = 0, wr_cnt = 0, clr_wr_cnt = 0, done_cnt = 0;
  logic [16:0] last_addr = '0;
  logic busy_exp = 1'b0, done_exp = 1'b0, acc_seen = 1'b0;
  logic prev_hold = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [2:0]  prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Pixel source: presents the queue head until the handshake is seen.
  always begin
    @(posedge clk);
    #2;
    if (acc_seen && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      in_valid  = 1'b1;
      in_x      = src_q[0].x;
      in_y      = src_q[0].y;
      in_colour = src_q[0].c;
    end else begin
      in_valid = 1'b0;
    end
  end

  // Compare process: current outputs against the model, then advance the model.
  always @(negedge clk) begin
    exp_t e;
    logic busy_now;
    if (reset) begin
      chk("reset_fb_we", fb_we, 0);
      chk("reset_fb_addr", fb_addr, 0);
      chk("reset_fb_data", fb_data, 0);
      chk("reset_clear_busy", clear_busy, 0);
      chk("reset_clear_done", clear_done, 0);
      chk("reset_in_ready", in_ready, 0);
      exp_q.delete();
      busy_exp  = 1'b0;
      done_exp  = 1'b0;
      acc_seen  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("clear_busy", clear_busy, busy_exp);
      chk("clear_done", clear_done, done_exp);
      if (busy_exp) chk("in_ready_during_clear", in_ready, 0);
      if (prev_hold) begin
        chk("stall_hold_we", fb_we, 1);
        chk("stall_hold_addr", fb_addr, prev_addr);
        chk("stall_hold_data", fb_data, prev_data);
      end
      if (clear_done) done_cnt++;
      busy_now = busy_exp;
      done_exp = 1'b0;
      if (fb_we && !fb_stall) begin
        wr_cnt++;
        last_addr = fb_addr;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got write to addr %0d, required no write", fb_addr);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", fb_addr, e.addr);
          chk("write_data", fb_data, e.data);
          if (e.is_clr) clr_wr_cnt++;
          if (e.last) begin
            done_exp = 1'b1;
            busy_exp = 1'b0;
          end
        end
      end
      prev_hold = fb_we && fb_stall;
      prev_addr = fb_addr;
      prev_data = fb_data;
      acc_seen  = in_valid && in_ready;
      if (acc_seen) begin
        acc_cnt++;
        if (int'(in_x) < HRes && int'(in_y) < VRes)
          exp_q.push_back('{addr: 17'(int'(in_y) * HRes + int'(in_x)), data: in_colour,
                            last: 1'b0, is_clr: 1'b0});
      end
      if (clear_req && !busy_now) begin
        busy_exp = 1'b1;
        for (int a = 0; a < Total; a++)
          exp_q.push_back('{addr: 17'(a), data: clear_colour, last: (a == Total - 1),
                            is_clr: 1'b1});
      end
    end
  end

  initial begin
    int a0, w0, c0, d0, n;
    tick(3);
    reset = 1'b0;
    #1;
    chk("ready_after_release", in_ready, 1);
    chk("we_after_release", fb_we, 0);
    tick(1);

    // Single pixel (10,2) colour 5 -> address 650, one cycle after accept.
    src_q.push_back('{x: 9'd10, y: 8'd2, c: 3'd5});
    tick(1);
    tick(1);
    chk("t1_we_at_accept", fb_we, 0);
    chk("t1_ready", in_ready, 1);
    tick(1);
    chk("t1_we", fb_we, 1);
    chk("t1_addr", fb_addr, 650);
    chk("t1_data", fb_data, 5);
    tick(3);

    // Burst of 6 under a 10-cycle stall: 5 taken, then written back to back.
    fb_stall = 1'b1;
    a0 = acc_cnt;
    for (int k = 0; k < 6; k++) src_q.push_back('{x: 9'(20 + k), y: 8'd3, c: 3'(k)});
    tick(10);
    chk("t2_accepted", acc_cnt - a0, 5);
    chk("t2_ready_full", in_ready, 0);
    chk("t2_we_held", fb_we, 1);
    chk("t2_addr_held", fb_addr, 980);
    fb_stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("t2_consec_we", fb_we, 1);
      chk("t2_consec_addr", fb_addr, 980 + i);
    end
    tick(3);
    chk("t2_all_accepted", acc_cnt - a0, 6);

    // Corner and out-of-range pixels.
    a0 = acc_cnt;
    w0 = wr_cnt;
    src_q.push_back('{x: 9'd319, y: 8'd239, c: 3'd2});
    src_q.push_back('{x: 9'd320, y: 8'd0, c: 3'd3});
    src_q.push_back('{x: 9'd0, y: 8'd240, c: 3'd4});
    tick(10);
    chk("t3_accepted", acc_cnt - a0, 3);
    chk("t3_writes", wr_cnt - w0, 1);
    chk("t3_last_addr", last_addr, 76799);
`ifdef FB_WRITER_DROP_COUNT_EN
    chk("t3_drop_count", drop_count, 2);
    chk("t3_drop_flag", drop_flag, 1);
`endif

    // Reset in the middle of a clear sweep.
    clear_colour = 3'd6;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    chk("t4_busy", clear_busy, 1);
    n = 0;
    while (!(fb_we && fb_addr == 17'd1000) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL t4_reach_1000: got no write at addr 1000 in %0d cycles, required one", n);
    end
    #2;
    reset = 1'b1;
    src_q.delete();
    #1;
    chk("t4_we_on_reset", fb_we, 0);
    chk("t4_busy_on_reset", clear_busy, 0);
    chk("t4_ready_on_reset", in_ready, 0);
    tick(2);
    reset = 1'b0;
    w0 = wr_cnt;
    tick(20);
    chk("t4_no_writes", wr_cnt - w0, 0);
    chk("t4_ready", in_ready, 1);
    chk("t4_busy_after", clear_busy, 0);
`ifdef FB_WRITER_DROP_COUNT_EN
    chk("t4_drop_cleared", drop_count, 0);
`endif

    // Full clear with buffered pixels and a toggling stall at the start.
    fb_stall = 1'b1;
    src_q.push_back('{x: 9'd5, y: 8'd5, c: 3'd1});
    src_q.push_back('{x: 9'd6, y: 8'd5, c: 3'd2});
    src_q.push_back('{x: 9'd7, y: 8'd5, c: 3'd3});
    tick(6);
    chk("t5_stalled_addr", fb_addr, 1605);
    c0 = clr_wr_cnt;
    d0 = done_cnt;
    w0 = wr_cnt;
    clear_colour = 3'd1;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    chk("t5_busy", clear_busy, 1);
    chk("t5_ready", in_ready, 0);
    for (int i = 0; i < 4000; i++) begin
      fb_stall = (i % 2) == 0;
      tick(1);
    end
    fb_stall = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 90000) begin
      tick(1);
      n++;
    end
    if (n >= 90000) begin
      n_checks++;
      n_fail++;
      $display("FAIL t5_clear_done_timeout: got no clear_done in %0d cycles, required one", n);
    end
    tick(3);
    chk("t5_clear_writes", clr_wr_cnt - c0, Total);
    chk("t5_total_writes", wr_cnt - w0, Total + 3);
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_last_addr", last_addr, 76799);
    chk("t5_busy_end", clear_busy, 0);
    chk("t5_ready_end", in_ready, 1);
    chk("t5_model_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
